// File: rtl/rv32_retire_pkg.sv
// Shared types for the rv32 retirement monitor: the trace record layout and its width.
package rv32_retire_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic        trap;
    } trace_rec_t;

    localparam int TRACE_REC_W = $bits(trace_rec_t);

    function automatic trace_rec_t make_rec(
        input logic [31:0] pc,
        input logic [31:0] insn,
        input logic [4:0]  rd_addr,
        input logic [31:0] rd_wdata,
        input logic        trap
    );
        trace_rec_t r;
        r.pc       = pc;
        r.insn     = insn;
        r.rd_addr  = rd_addr;
        r.rd_wdata = rd_wdata;
        r.trap     = trap;
        return r;
    endfunction

endpackage

// File: rtl/rv32_retire_fifo.sv
// First-word-fall-through FIFO of trace records; a push into a full FIFO is
// accepted only when a pop retires the head in the same cycle.
module rv32_retire_fifo
    import rv32_retire_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  trace_rec_t push_data_i,
    output logic       full_o,
    input  logic       pop_i,
    output trace_rec_t pop_data_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    trace_rec_t     mem [DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic           wr_en;
    logic           rd_en;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rd_en = pop_i && !empty_o;
    assign wr_en = push_i && (!full_o || rd_en);

    assign pop_data_o = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/rv32_retire_monitor.sv
// RVFI retirement monitor: counts retirements, buffers trace records, drops on full.
// Stream consistency checks are built only when RV32_RETIRE_CHECK_EN is defined.
module rv32_retire_monitor
    import rv32_retire_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_i,
    input  logic              clear_in,
    input  logic              rvfi_valid,
    input  logic [63:0]       rvfi_order,
    input  logic [31:0]       rvfi_insn,
    input  logic              rvfi_trap,
    input  logic              rvfi_intr,
    input  logic [31:0]       rvfi_pc_rdata,
    input  logic [31:0]       rvfi_pc_wdata,
    input  logic [4:0]        rvfi_rd_addr,
    input  logic [31:0]       rvfi_rd_wdata,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [31:0]       trace_pc,
    output logic [31:0]       trace_insn,
    output logic [31:0]       trace_rd_wdata,
    output logic [4:0]        trace_rd_addr,
    output logic              trace_trap,
    output logic [63:0]       retired_count,
    output logic [DROP_W-1:0] drop_count,
    output logic              overflow,
    output logic              err_order,
    output logic              err_pc,
    output logic              err_x0
);

    logic       capture;
    logic       clear_act;
    logic       pop;
    logic       push;
    logic       drop;
    logic       fifo_full;
    logic       fifo_empty;
    trace_rec_t cap_rec;
    trace_rec_t head_rec;

    logic [63:0]       retired_count_q, retired_count_d;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;
    logic              overflow_q, overflow_d;

    assign capture   = ce_i && rvfi_valid;
    assign clear_act = ce_i && clear_in;
    assign pop       = ce_i && !fifo_empty && trace_ready;
    // A full FIFO still takes the record when the head leaves in the same cycle.
    assign push      = capture && (!fifo_full || pop);
    assign drop      = capture && fifo_full && !pop;

    assign cap_rec = make_rec(rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr,
                              rvfi_rd_wdata, rvfi_trap);

    rv32_retire_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (cap_rec),
        .full_o      (fifo_full),
        .pop_i       (pop),
        .pop_data_o  (head_rec),
        .empty_o     (fifo_empty)
    );

    assign trace_valid    = !fifo_empty;
    assign trace_pc       = head_rec.pc;
    assign trace_insn     = head_rec.insn;
    assign trace_rd_addr  = head_rec.rd_addr;
    assign trace_rd_wdata = head_rec.rd_wdata;
    assign trace_trap     = head_rec.trap;

    always_comb begin
        retired_count_d = retired_count_q;
        drop_count_d    = drop_count_q;
        overflow_d      = overflow_q;
        if (capture) begin
            retired_count_d = retired_count_q + 64'd1;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != {DROP_W{1'b1}}) begin
                drop_count_d = drop_count_q + 1'b1;
            end
        end
        if (clear_act) begin
            retired_count_d = '0;
            drop_count_d    = '0;
            overflow_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_count_q <= '0;
            drop_count_q    <= '0;
            overflow_q      <= 1'b0;
        end else begin
            retired_count_q <= retired_count_d;
            drop_count_q    <= drop_count_d;
            overflow_q      <= overflow_d;
        end
    end

    assign retired_count = retired_count_q;
    assign drop_count    = drop_count_q;
    assign overflow      = overflow_q;

`ifdef RV32_RETIRE_CHECK_EN
    logic [63:0] prev_order_q, prev_order_d;
    logic [31:0] prev_pc_q, prev_pc_d;
    logic        have_prev_q, have_prev_d;
    logic        err_order_q, err_order_d;
    logic        err_pc_q, err_pc_d;
    logic        err_x0_q, err_x0_d;

    always_comb begin
        prev_order_d = prev_order_q;
        prev_pc_d    = prev_pc_q;
        have_prev_d  = have_prev_q;
        err_order_d  = err_order_q;
        err_pc_d     = err_pc_q;
        err_x0_d     = err_x0_q;
        if (capture) begin
            if (have_prev_q) begin
                if (rvfi_order != prev_order_q + 64'd1) begin
                    err_order_d = 1'b1;
                end
                // Trap-handler entry legitimately redirects the PC.
                if (!rvfi_intr && (rvfi_pc_rdata != prev_pc_q)) begin
                    err_pc_d = 1'b1;
                end
            end
            if ((rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0)) begin
                err_x0_d = 1'b1;
            end
            prev_order_d = rvfi_order;
            prev_pc_d    = rvfi_pc_wdata;
            have_prev_d  = 1'b1;
        end
        if (clear_act) begin
            err_order_d = 1'b0;
            err_pc_d    = 1'b0;
            err_x0_d    = 1'b0;
            have_prev_d = capture;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_order_q <= '0;
            prev_pc_q    <= '0;
            have_prev_q  <= 1'b0;
            err_order_q  <= 1'b0;
            err_pc_q     <= 1'b0;
            err_x0_q     <= 1'b0;
        end else begin
            prev_order_q <= prev_order_d;
            prev_pc_q    <= prev_pc_d;
            have_prev_q  <= have_prev_d;
            err_order_q  <= err_order_d;
            err_pc_q     <= err_pc_d;
            err_x0_q     <= err_x0_d;
        end
    end

    assign err_order = err_order_q;
    assign err_pc    = err_pc_q;
    assign err_x0    = err_x0_q;
`else
    logic unused_chk;
    assign unused_chk = ^{rvfi_order, rvfi_intr, rvfi_pc_wdata};

    assign err_order = 1'b0;
    assign err_pc    = 1'b0;
    assign err_x0    = 1'b0;
`endif

endmodule
